div_request_sequencer: RTL and testbench

//  Stream front-end for the signed non-restoring divider core. Buffers (numerator, denominator, tag)

---
 rtl/div_request_sequencer_if.sv | 48 ++++
 rtl/div_request_sequencer.sv | 134 +++++++++++++
 tb/tb_div_request_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_request_sequencer_if.sv
// Bus bundle for div_request_sequencer: request stream (s_*), divider core
// link (div_*) and result stream (m_*). The sequencer takes the slave view,
// and the surrounding environment (producer, core, consumer) takes the master view.
interface div_request_sequencer_if #(
  parameter int DATA_W = 12,
  parameter int TAG_W  = 4
);
  // request stream
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_numerator;
  logic [DATA_W-1:0] s_denominator;
  logic [TAG_W-1:0]  s_tag;
  // divider core link
  logic              div_resetn;
  logic [DATA_W-1:0] div_numerator;
  logic [DATA_W-1:0] div_denominator;
  logic              div_valid;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;
  logic              div_ready;
  logic              div_error;
  // result stream
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_quotient;
  logic [DATA_W-1:0] m_remainder;
  logic [TAG_W-1:0]  m_tag;
  logic              m_err_div0;

  modport slave (
    input  s_valid, s_numerator, s_denominator, s_tag,
    output s_ready,
    output div_resetn, div_numerator, div_denominator, div_valid,
    input  div_quotient, div_remainder, div_ready, div_error,
    output m_valid, m_quotient, m_remainder, m_tag, m_err_div0,
    input  m_ready
  );

  modport master (
    output s_valid, s_numerator, s_denominator, s_tag,
    input  s_ready,
    input  div_resetn, div_numerator, div_denominator, div_valid,
    output div_quotient, div_remainder, div_ready, div_error,
    input  m_valid, m_quotient, m_remainder, m_tag, m_err_div0,
    output m_ready
  );
endinterface

// File: rtl/div_request_sequencer.sv
// div_request_sequencer: FIFO-buffered front-end for the signed divider core.
// Requests are queued, issued one at a time with a single-cycle start strobe,
// and the core's done / div-by-zero pulse is captured into a one-entry
// valid/ready result register. Only one request is ever in the core.
// Optional build macro DIV_SEQ_ZERO_BYPASS_EN: a zero denominator at the FIFO
// head is completed locally as a div-by-zero result, never reaching the core.
module div_request_sequencer #(
  parameter int DATA_W     = 12,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  aclk,
  input logic                  reset,
  div_request_sequencer_if.slave bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [DATA_W-1:0] fifo_num [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_den [FIFO_DEPTH];
  logic [TAG_W-1:0]  fifo_tag [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [1:0]        state;
  logic [TAG_W-1:0]  tag_r;
  logic [DATA_W-1:0] num_r, den_r;

  logic full, empty, push, pop, issue, bypass, out_free, core_done;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // held low during reset so every output reads 0 while reset is high
  assign bus.s_ready = !reset && !full;
  assign push     = bus.s_valid && bus.s_ready;
  assign out_free = !bus.m_valid || bus.m_ready;
  // a head is taken only when the result register can absorb its answer
  assign pop      = (state == IDLE) && !empty && out_free;
  // core pulses are meaningful only while a request is outstanding
  assign core_done = (state == WAIT) && (bus.div_ready || bus.div_error);

`ifdef DIV_SEQ_ZERO_BYPASS_EN
  logic head_zero;
  assign head_zero = (fifo_den[rd_ptr] == '0);
  assign bypass    = pop && head_zero;
  assign issue     = pop && !head_zero;
`else
  assign bypass    = 1'b0;
  assign issue     = pop;
`endif

  assign bus.div_resetn      = ~reset;
  assign bus.div_valid       = (state == ISSUE);
  assign bus.div_numerator   = num_r;
  assign bus.div_denominator = den_r;

  // FIFO storage write; contents need no reset, count/pointers gate validity
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_num[wr_ptr] <= bus.s_numerator;
      fifo_den[wr_ptr] <= bus.s_denominator;
      fifo_tag[wr_ptr] <= bus.s_tag;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // issue FSM and operand/tag hold registers for the in-flight request
  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= IDLE;
      num_r <= '0;
      den_r <= '0;
      tag_r <= '0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          num_r <= fifo_num[rd_ptr];
          den_r <= fifo_den[rd_ptr];
          tag_r <= fifo_tag[rd_ptr];
          state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT:  if (core_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // result register: core completion or local bypass loads, handshake drains
  always_ff @(posedge aclk) begin
    if (reset) begin
      bus.m_valid     <= 1'b0;
      bus.m_quotient  <= '0;
      bus.m_remainder <= '0;
      bus.m_tag       <= '0;
      bus.m_err_div0  <= 1'b0;
    end else if (core_done) begin
      // error wins when both pulses coincide
      bus.m_valid     <= 1'b1;
      bus.m_tag       <= tag_r;
      bus.m_err_div0  <= bus.div_error;
      bus.m_quotient  <= bus.div_error ? '0 : bus.div_quotient;
      bus.m_remainder <= bus.div_error ? '0 : bus.div_remainder;
    end else if (bypass) begin
      bus.m_valid     <= 1'b1;
      bus.m_tag       <= fifo_tag[rd_ptr];
      bus.m_err_div0  <= 1'b1;
      bus.m_quotient  <= '0;
      bus.m_remainder <= '0;
    end else if (bus.m_ready) begin
      bus.m_valid     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_div_request_sequencer.sv
// Bench for div_request_sequencer with a behavioural signed divider core.
// Directed requests push hand-computed results into a scoreboard; a monitor
// pops and compares on every accepted result beat.
module tb_div_request_sequencer;
  logic aclk = 1'b0;
  logic reset = 1'b1;
  always #5 aclk = ~aclk;

  div_request_sequencer_if #(.DATA_W(12), .TAG_W(4)) bus();

  div_request_sequencer #(.DATA_W(12), .TAG_W(4), .FIFO_DEPTH(4)) dut (
    .aclk(aclk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [11:0] q;
    logic [11:0] r;
    logic [3:0]  tag;
    logic        err;
  } res_t;

  res_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   issue_cnt = 0;
  bit   inject = 1'b0;
  bit   tog_en = 1'b0;
  bit   mr_set = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // m_ready driver: either a fixed level or toggling every cycle
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      bus.m_ready = tog_en ? ~bus.m_ready : mr_set;
    end
  end

  // behavioural divider core: 3-cycle latency, div-by-zero reported the cycle after start
  initial begin
    logic signed [11:0] cn, cd;
    int cnt;
    bit busy;
    busy = 0; cnt = 0; cn = '0; cd = '0;
    bus.div_ready = 0; bus.div_error = 0;
    bus.div_quotient = '0; bus.div_remainder = '0;
    forever begin
      @(negedge aclk);
      bus.div_ready = 0;
      bus.div_error = 0;
      if (!bus.div_resetn) begin
        busy = 0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 0;
            if (cd == 0) bus.div_error = 1;
            else begin
              bus.div_ready     = 1;
              bus.div_quotient  = cn / cd;
              bus.div_remainder = cn % cd;
            end
          end
        end
        if (bus.div_valid) begin
          busy = 1;
          cn = $signed(bus.div_numerator);
          cd = $signed(bus.div_denominator);
          cnt = (cd == 0) ? 1 : 3;
        end
        if (inject) begin
          bus.div_ready     = 1;
          bus.div_quotient  = 12'h5A5;
          bus.div_remainder = 12'h0A5;
        end
      end
    end
  end

  // monitor: result scoreboard and start-strobe width
  initial begin
    res_t e;
    bit prev_dv;
    prev_dv = 0;
    forever begin
      @(negedge aclk);
      if (!reset && bus.div_valid) begin
        issue_cnt++;
        chk("div_valid_single_cycle", 32'(prev_dv), 0);
      end
      prev_dv = bus.div_valid;
      if (!reset && bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result_tag", 32'(bus.m_tag), 32'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("m_quotient", 32'(bus.m_quotient), 32'(e.q));
          chk("m_remainder", 32'(bus.m_remainder), 32'(e.r));
          chk("m_tag", 32'(bus.m_tag), 32'(e.tag));
          chk("m_err_div0", 32'(bus.m_err_div0), 32'(e.err));
        end
      end
    end
  end

  task automatic push(input int n, input int d, input int t, input int q, input int r,
                      input bit e, input bit exp_it);
    int w;
    res_t x;
    w = 0;
    bus.s_valid = 1'b1;
    bus.s_numerator = 12'(n);
    bus.s_denominator = 12'(d);
    bus.s_tag = 4'(t);
    while (!bus.s_ready && w < 300) begin
      @(posedge aclk); #1;
      w++;
    end
    if (!bus.s_ready) begin
      chk("push_timeout", 0, 1);
      bus.s_valid = 1'b0;
      return;
    end
    if (exp_it) begin
      x.q = 12'(q); x.r = 12'(r); x.tag = 4'(t); x.err = e;
      sb.push_back(x);
    end
    @(posedge aclk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || bus.m_valid) && w < 1000) begin
      @(posedge aclk); #1;
      w++;
    end
    chk("drain_pending", 32'(sb.size()), 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  // 20-request table for the m_ready toggling run: n, d, tag, q, r, err
  int vn[20] = '{123, -123, 2047, -2048, 2047, 5, -5, 64, 1000, -999,
                 17, 300, -300, 1, 0, -1, 2000, -2000, 511, -512};
  int vd[20] = '{10, 10, 1, 1, -1, 7, 7, 8, -33, -37,
                 0, 17, -17, 1, -5, 2, 45, 45, -2, 3};
  int vq[20] = '{12, -12, 2047, -2048, -2047, 0, 0, 8, -30, 27,
                 0, 17, 17, 1, 0, 0, 44, -44, -255, -170};
  int vr[20] = '{3, -3, 0, 0, 0, 5, -5, 0, 10, 0,
                 0, 11, -11, 0, 0, -1, 20, -20, 1, -2};

  initial begin
    int base;
    bus.s_valid = 0; bus.s_numerator = '0; bus.s_denominator = '0; bus.s_tag = '0;
    mr_set = 1'b1;

    // reset state
    cycles(3);
    @(negedge aclk);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_div_valid", 32'(bus.div_valid), 0);
    chk("rst_div_resetn", 32'(bus.div_resetn), 0);
    chk("rst_m_quotient", 32'(bus.m_quotient), 0);
    @(posedge aclk); #1;
    reset = 1'b0;
    @(negedge aclk);
    chk("post_rst_s_ready", 32'(bus.s_ready), 1);
    chk("post_rst_div_resetn", 32'(bus.div_resetn), 1);
    @(posedge aclk); #1;

    // single positive divide
    base = issue_cnt;
    push(100, 7, 3, 14, 2, 0, 1);
    drain();
    chk("t1_issue_count", 32'(issue_cnt - base), 1);

    // back-to-back signed cases
    push(-100, 7, 5, -14, -2, 0, 1);
    push(100, -7, 6, -14, 2, 0, 1);
    drain();

    // divide by zero
    base = issue_cnt;
    push(9, 0, 1, 0, 0, 1, 1);
    drain();
`ifdef DIV_SEQ_ZERO_BYPASS_EN
    chk("t3_issue_count", 32'(issue_cnt - base), 0);
`else
    chk("t3_issue_count", 32'(issue_cnt - base), 1);
`endif

    // stall: one result held plus four queued, sixth request must wait
    mr_set = 1'b0;
    cycles(2);
    push(50, 5, 8, 10, 0, 0, 1);
    push(-50, 5, 9, -10, 0, 0, 1);
    push(77, -10, 10, -7, 7, 0, 1);
    push(-77, -10, 11, 7, -7, 0, 1);
    push(11, 3, 12, 3, 2, 0, 1);
    cycles(10);
    @(negedge aclk);
    chk("t4_s_ready_full", 32'(bus.s_ready), 0);
    chk("t4_m_valid_held", 32'(bus.m_valid), 1);
    chk("t4_m_tag_held", 32'(bus.m_tag), 8);
    @(posedge aclk); #1;
    fork
      push(0, 9, 13, 0, 0, 0, 1);
      begin cycles(4); mr_set = 1'b1; end
    join
    drain();

    // reset while the core is busy: request dropped, stray done ignored
    bus.s_valid = 1'b1; bus.s_numerator = 12'd1000; bus.s_denominator = 12'd3; bus.s_tag = 4'd2;
    @(posedge aclk); #1;
    bus.s_valid = 1'b0;
    begin
      int w;
      w = 0;
      while (!bus.div_valid && w < 20) begin @(negedge aclk); w++; end
      chk("t5_div_valid_seen", 32'(bus.div_valid), 1);
    end
    @(posedge aclk); #1;
    reset = 1'b1;
    @(posedge aclk); #1;
    reset = 1'b0;
    @(negedge aclk);
    chk("t5_s_ready", 32'(bus.s_ready), 1);
    chk("t5_m_valid", 32'(bus.m_valid), 0);
    @(posedge aclk); #1;
    base = issue_cnt;
    inject = 1'b1;
    @(posedge aclk); #1;
    inject = 1'b0;
    cycles(5);
    @(negedge aclk);
    chk("t5_stray_ignored", 32'(bus.m_valid), 0);
    chk("t5_no_issue", 32'(issue_cnt - base), 0);
    @(posedge aclk); #1;
    push(1000, 3, 2, 333, 1, 0, 1);
    drain();

    // m_ready toggling over 20 requests
    base = issue_cnt;
    tog_en = 1'b1;
    for (int i = 0; i < 20; i++)
      push(vn[i], vd[i], i % 16, vq[i], vr[i], vd[i] == 0, 1);
    drain();
    tog_en = 1'b0;
    mr_set = 1'b1;
`ifdef DIV_SEQ_ZERO_BYPASS_EN
    chk("t6_issue_count", 32'(issue_cnt - base), 19);
`else
    chk("t6_issue_count", 32'(issue_cnt - base), 20);
`endif
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
